// File: rtl/i2c_master_ctrl.sv
// I2C bus master: START, ID+R/W, two address bytes, 16 data bits, STOP.
// Generates SCL/SDA from a half-period timer; the register slave answers ACKs.
module i2c_master_ctrl #(
   parameter int HALF = 125
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        start,
   input  logic [6:0]  dev_id,
   input  logic        rnw,
   input  logic [15:0] reg_addr,
   input  logic [15:0] wr_data,
   input  logic        iSDA,
   output logic        SCL,
   output logic        oSDA,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic [15:0] rd_data
);

   localparam int TW = (HALF > 2) ? $clog2(HALF) : 2;
   localparam logic [TW-1:0] T_END = TW'(HALF - 1);
   localparam logic [TW-1:0] T_MID = TW'(HALF / 2);
   localparam logic [TW-1:0] T_ONE = TW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START_HOLD,
      BIT_LOW,
      BIT_HIGH,
      STOP_LOW,
      STOP_HIGH,
      STOP_FREE
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [5:0]    bit_cnt, bit_n;
   logic [39:0]   sh, sh_n;
   logic [15:0]   shadow, shadow_n;
   logic          rnw_q, rnw_n;
   logic          nack, nack_n;
   logic          scl_n, sda_n, busy_n, done_n, err_n;
   logic [15:0]   rd_n;

   logic tend, is_ack, is_data, drive, last;

   assign tend    = (timer == T_END);
   assign is_ack  = (bit_cnt == 6'd8) || (bit_cnt == 6'd17) || (bit_cnt == 6'd26);
   assign is_data = (bit_cnt >= 6'd27);
   assign drive   = !is_ack && !(is_data && rnw_q);
   assign last    = (bit_cnt == 6'd42);

   always_comb begin
      state_n  = state;
      timer_n  = timer;
      bit_n    = bit_cnt;
      sh_n     = sh;
      shadow_n = shadow;
      rnw_n    = rnw_q;
      nack_n   = nack;
      scl_n    = SCL;
      sda_n    = oSDA;
      busy_n   = busy;
      done_n   = 1'b0;
      err_n    = ack_err;
      rd_n     = rd_data;
      if (state != IDLE) begin
         timer_n = tend ? '0 : timer + T_ONE;
      end
      unique case (state)
         IDLE: begin
            scl_n   = 1'b1;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
            timer_n = '0;
            if (start) begin
               sh_n    = {dev_id, rnw, reg_addr, wr_data};
               rnw_n   = rnw;
               err_n   = 1'b0;
               nack_n  = 1'b0;
               bit_n   = '0;
               busy_n  = 1'b1;
               sda_n   = 1'b0;
               state_n = START_HOLD;
            end
         end
         START_HOLD: begin
            if (tend) begin
               scl_n   = 1'b0;
               state_n = BIT_LOW;
            end
         end
         BIT_LOW: begin
            // SDA moves one cycle after SCL falls so the two never toggle together
            if (timer == '0) begin
               sda_n = drive ? sh[39] : 1'b1;
            end
            if (tend) begin
               scl_n   = 1'b1;
               state_n = BIT_HIGH;
            end
         end
         BIT_HIGH: begin
            if (timer == T_MID) begin
               if (is_ack) begin
                  nack_n = iSDA;
                  if (iSDA) begin
                     err_n = 1'b1;
                  end
               end else if (is_data && rnw_q) begin
                  shadow_n = {shadow[14:0], iSDA};
               end
            end
            if (tend) begin
               scl_n = 1'b0;
               bit_n = bit_cnt + 6'd1;
               if (drive) begin
                  sh_n = {sh[38:0], 1'b0};
               end
               state_n = (nack || last) ? STOP_LOW : BIT_LOW;
            end
         end
         STOP_LOW: begin
            if (timer == '0) begin
               sda_n = 1'b0;
            end
            if (tend) begin
               scl_n   = 1'b1;
               state_n = STOP_HIGH;
            end
         end
         STOP_HIGH: begin
            if (tend) begin
               sda_n   = 1'b1;
               state_n = STOP_FREE;
            end
         end
         STOP_FREE: begin
            if (tend) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = IDLE;
               if (rnw_q && !ack_err) begin
                  rd_n = shadow;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         sh      <= '0;
         shadow  <= '0;
         rnw_q   <= 1'b0;
         nack    <= 1'b0;
         SCL     <= 1'b1;
         oSDA    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rd_data <= '0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         bit_cnt <= bit_n;
         sh      <= sh_n;
         shadow  <= shadow_n;
         rnw_q   <= rnw_n;
         nack    <= nack_n;
         SCL     <= scl_n;
         oSDA    <= sda_n;
         busy    <= busy_n;
         done    <= done_n;
         ack_err <= err_n;
         rd_data <= rd_n;
      end
   end

endmodule
